// File: rtl/cam_key_lookup.sv
// Search side of the image CAM: stores key/ID pairs in arrival order and answers
// lookups by scanning one entry per clock, returning the lowest-index match.
module cam_key_lookup #(
  parameter int KEY_W = 24,
  parameter int ID_W  = 14,
  parameter int DEPTH = 16,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [KEY_W-1:0] wr_key,
  input  logic [ID_W-1:0]  wr_id,
  input  logic             clear,
  output logic             full,
  output logic             wr_err,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [KEY_W-1:0] req_key,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_hit,
  output logic [ID_W-1:0]  rsp_id,
  output logic [IDX_W-1:0] rsp_idx,
  output logic [IDX_W:0]   count
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [IDX_W:0] CNT_FULL = (IDX_W+1)'(DEPTH);
  localparam logic [IDX_W:0] CNT_ONE  = (IDX_W+1)'(1);

  logic [KEY_W-1:0] key_mem [DEPTH];
  logic [ID_W-1:0]  id_mem  [DEPTH];

  logic [1:0]       state_q, state_d;
  logic [IDX_W:0]   count_q, count_d;
  logic [IDX_W-1:0] scan_q, scan_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic             hit_q, hit_d;
  logic [ID_W-1:0]  rid_q, rid_d;
  logic [IDX_W-1:0] ridx_q, ridx_d;
  logic             wr_err_q, wr_err_d;

  logic idle, req_acc, clr, wr_acc, match, last;

  assign idle    = (state_q == S_IDLE);
  assign req_acc = idle & req_valid;
  assign clr     = idle & clear;
  // A request in the same cycle wins over a write; clear wins over both.
  assign wr_acc  = idle & we & ~full & ~clear & ~req_valid;
  assign match   = (key_mem[scan_q] == key_q);
  assign last    = ({1'b0, scan_q} == (count_q - CNT_ONE));

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    scan_d   = scan_q;
    key_d    = key_q;
    hit_d    = hit_q;
    rid_d    = rid_q;
    ridx_d   = ridx_q;
    wr_err_d = we & ~clr & ~wr_acc;
    case (state_q)
      S_IDLE: begin
        if (clr)         count_d = '0;
        else if (wr_acc) count_d = count_q + CNT_ONE;
        if (req_acc) begin
          key_d  = req_key;
          scan_d = '0;
          // A same-cycle clear empties the table, so the request sees it empty.
          if (count_q == '0 || clr) begin
            state_d = S_DONE;
            hit_d   = 1'b0;
            rid_d   = '0;
            ridx_d  = '0;
          end else begin
            state_d = S_SCAN;
          end
        end
      end
      S_SCAN: begin
        if (match) begin
          state_d = S_DONE;
          hit_d   = 1'b1;
          rid_d   = id_mem[scan_q];
          ridx_d  = scan_q;
        end else if (last) begin
          state_d = S_DONE;
          hit_d   = 1'b0;
          rid_d   = '0;
          ridx_d  = '0;
        end else begin
          scan_d = scan_q + 1'b1;
        end
      end
      S_DONE: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      scan_q   <= '0;
      hit_q    <= 1'b0;
      rid_q    <= '0;
      ridx_q   <= '0;
      wr_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      scan_q   <= scan_d;
      hit_q    <= hit_d;
      rid_q    <= rid_d;
      ridx_q   <= ridx_d;
      wr_err_q <= wr_err_d;
    end
  end

  // Key/ID storage and the latched search key carry no reset.
  always_ff @(posedge clk) begin
    key_q <= key_d;
    if (wr_acc) begin
      key_mem[count_q[IDX_W-1:0]] <= wr_key;
      id_mem[count_q[IDX_W-1:0]]  <= wr_id;
    end
  end

  assign req_ready = idle;
  assign rsp_valid = (state_q == S_DONE);
  assign rsp_hit   = hit_q;
  assign rsp_id    = rid_q;
  assign rsp_idx   = ridx_q;
  assign wr_err    = wr_err_q;
  assign full      = (count_q == CNT_FULL);
  assign count     = count_q;

endmodule

// File: tb/tb_cam_key_lookup.sv
// Bench for cam_key_lookup: a driver pushes expected responses into a queue and
// a negedge monitor pops and checks each response, its timing and its stability.
module tb_cam_key_lookup;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        we = 1'b0;
  logic [23:0] wr_key = '0;
  logic [13:0] wr_id = '0;
  logic        clear = 1'b0;
  logic        full, wr_err;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [23:0] req_key = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic        rsp_hit;
  logic [13:0] rsp_id;
  logic [3:0]  rsp_idx;
  logic [4:0]  count;

  cam_key_lookup #(.KEY_W(24), .ID_W(14), .DEPTH(16), .IDX_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .we(we), .wr_key(wr_key), .wr_id(wr_id),
    .clear(clear), .full(full), .wr_err(wr_err),
    .req_valid(req_valid), .req_ready(req_ready), .req_key(req_key),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hit(rsp_hit),
    .rsp_id(rsp_id), .rsp_idx(rsp_idx), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        hit;
    logic [13:0] id;
    logic [3:0]  idx;
    logic [31:0] edge_t;
  } exp_t;

  exp_t q[$];
  int   n_pass = 0;
  int   n_tot  = 0;
  int   cyc    = 0;
  bit   in_rsp = 1'b0;
  exp_t held;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: first valid cycle pops and checks; later cycles check hold stability.
  always @(negedge clk) begin
    if (rsp_valid) begin
      if (!in_rsp) begin
        if (q.size() == 0) begin
          chk("unexpected_rsp", 32'd1, 32'd0);
        end else begin
          held = q.pop_front();
          chk("rsp_edge", 32'(cyc + 1), held.edge_t);
          chk("rsp_hit",  {31'd0, rsp_hit}, {31'd0, held.hit});
          chk("rsp_id",   {18'd0, rsp_id},  {18'd0, held.id});
          chk("rsp_idx",  {28'd0, rsp_idx}, {28'd0, held.idx});
        end
        in_rsp = 1'b1;
      end else begin
        chk("hold_stable", {13'd0, rsp_hit, rsp_id, rsp_idx}, {13'd0, held.hit, held.id, held.idx});
        chk("hold_req_ready", {31'd0, req_ready}, 32'd0);
      end
      if (rsp_ready) in_rsp = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [23:0] k, input logic [13:0] id);
    we = 1'b1; wr_key = k; wr_id = id;
    step();
    we = 1'b0;
  endtask

  // Issues one request; when push is set, enqueues the expected response at edge T+lat.
  task automatic issue(input logic [23:0] k, input bit push, input logic hit,
                       input logic [13:0] id, input logic [3:0] idx, input int lat);
    exp_t e;
    req_valid = 1'b1; req_key = k;
    chk("req_ready_at_accept", {31'd0, req_ready}, 32'd1);
    step();
    req_valid = 1'b0;
    e.hit = hit; e.id = id; e.idx = idx; e.edge_t = 32'(cyc + lat);
    if (push) q.push_back(e);
  endtask

  task automatic wait_rsp();
    bit done = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (q.size() == 0 && !in_rsp) begin done = 1'b1; break; end
      step();
    end
    if (!done) chk("rsp_timeout", 32'd1, 32'd0);
  endtask

  task automatic lookup(input logic [23:0] k, input logic hit, input logic [13:0] id,
                        input logic [3:0] idx, input int lat);
    issue(k, 1'b1, hit, id, idx, lat);
    wait_rsp();
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    bit seen;
    #2;
    chk("rst_count",     {27'd0, count}, 32'd0);
    chk("rst_ready",     {31'd0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_outs",      {12'd0, rsp_hit, rsp_id, rsp_idx, full, wr_err}, 32'd0);
    step();
    rst_n = 1'b1;
    step();

    // Empty table: immediate miss.
    lookup(24'hFF00F2, 1'b0, 14'd0, 4'd0, 1);
    chk("empty_count", {27'd0, count}, 32'd0);

    wr(24'hFF00F2, 14'd1);
    wr(24'hAAAAAA, 14'd2);
    lookup(24'hAAAAAA, 1'b1, 14'd2, 4'd1, 3);
    chk("two_count", {27'd0, count}, 32'd2);

    // Response held under back-pressure for 5 cycles.
    rsp_ready = 1'b0;
    issue(24'hFF00F2, 1'b1, 1'b1, 14'd1, 4'd0, 2);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (in_rsp) begin seen = 1'b1; break; end
      step();
    end
    if (!seen) chk("hold_timeout", 32'd1, 32'd0);
    repeat (5) step();
    chk("hold_valid", {31'd0, rsp_valid}, 32'd1);
    rsp_ready = 1'b1;
    step();
    chk("post_hs_ready", {31'd0, req_ready}, 32'd1);
    chk("post_hs_valid", {31'd0, rsp_valid}, 32'd0);
    wait_rsp();

    // Fill all 16 entries, then overflow.
    clear = 1'b1; step(); clear = 1'b0;
    chk("clear_count", {27'd0, count}, 32'd0);
    for (int i = 0; i < 16; i++) wr(24'(i), 14'(i + 100));
    chk("full_count", {27'd0, count}, 32'd16);
    chk("full_flag",  {31'd0, full}, 32'd1);
    chk("no_err_fill", {31'd0, wr_err}, 32'd0);
    wr(24'h000011, 14'd999);
    chk("overflow_err", {31'd0, wr_err}, 32'd1);
    step();
    chk("overflow_err_end", {31'd0, wr_err}, 32'd0);
    chk("overflow_count", {27'd0, count}, 32'd16);
    lookup(24'h00000F, 1'b1, 14'd115, 4'd15, 17);
    lookup(24'h123456, 1'b0, 14'd0, 4'd0, 17);

    // Duplicate keys: lowest index wins.
    clear = 1'b1; step(); clear = 1'b0;
    wr(24'h000010, 14'd20);
    wr(24'h000011, 14'd21);
    wr(24'h0000AB, 14'd7);
    wr(24'h000013, 14'd23);
    wr(24'h000014, 14'd24);
    wr(24'h0000AB, 14'd9);
    lookup(24'h0000AB, 1'b1, 14'd7, 4'd2, 4);

    // Write during SCAN is rejected.
    issue(24'h999999, 1'b1, 1'b0, 14'd0, 4'd0, 7);
    wr(24'h0000CD, 14'd55);
    chk("scan_wr_err", {31'd0, wr_err}, 32'd1);
    step();
    chk("scan_wr_err_end", {31'd0, wr_err}, 32'd0);
    chk("scan_count", {27'd0, count}, 32'd6);
    wait_rsp();
    chk("after_scan_count", {27'd0, count}, 32'd6);

    // clear beats a same-cycle write, silently.
    clear = 1'b1;
    wr(24'h0000EE, 14'd3);
    clear = 1'b0;
    chk("clr_we_count", {27'd0, count}, 32'd0);
    chk("clr_we_no_err", {31'd0, wr_err}, 32'd0);

    // Reset during SCAN aborts the request.
    wr(24'h000001, 14'd1);
    wr(24'h000002, 14'd2);
    wr(24'h000003, 14'd3);
    issue(24'h777777, 1'b0, 1'b0, 14'd0, 4'd0, 4);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("mid_rst_ready", {31'd0, req_ready}, 32'd1);
    chk("mid_rst_count", {27'd0, count}, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    lookup(24'h000002, 1'b0, 14'd0, 4'd0, 1);

    step();
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
